// File: rtl/bus_sequencer_pkg.sv
// Shared types and constants for the bus sequencer: state encoding,
// bus-source select indices and default widths.
package bus_sequencer_pkg;

  localparam int SEL_W = 24;
  localparam int OP_W  = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    T_A   = 3'd1,
    T_B   = 3'd2,
    T_WLO = 3'd3,
    T_WHI = 3'd4,
    DONE  = 3'd5
  } state_t;

  // bus_sel bit positions; R0..R15 occupy bits 0..15
  localparam int SEL_R0     = 0;
  localparam int SEL_HI     = 16;
  localparam int SEL_LO     = 17;
  localparam int SEL_ZHI    = 18;
  localparam int SEL_ZLO    = 19;
  localparam int SEL_PC     = 20;
  localparam int SEL_MDR    = 21;
  localparam int SEL_INPORT = 22;
  localparam int SEL_C      = 23;

endpackage

// File: rtl/bus_sequencer_sel_decoder.sv
// 4-bit register index to 16-bit one-hot enable, gated by en.
module sel_decoder (
  input  logic [3:0]  idx,
  input  logic        en,
  output logic [15:0] onehot
);

  assign onehot = en ? (16'd1 << idx) : 16'd0;

endmodule

// File: rtl/bus_sequencer.sv
// Register-transfer sequencer: A -> Y, B op Y -> Z, Z -> dst (or Z -> HI/LO).
// Macro BUS_SEQUENCER_HILO_EN enables the 64-bit HI/LO write-back path.
module bus_sequencer #(
  parameter int SEL_W = 24,
  parameter int OP_W  = 5
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             start,
  input  logic [3:0]       src_a,
  input  logic [3:0]       src_b,
  input  logic [3:0]       dst,
  input  logic [OP_W-1:0]  op,
  input  logic             wide,
  output logic [SEL_W-1:0] bus_sel,
  output logic [15:0]      reg_in,
  output logic             y_in,
  output logic             z_in,
  output logic             hi_in,
  output logic             lo_in,
  output logic [OP_W-1:0]  alu_op,
  output logic             busy,
  output logic             done
);

  import bus_sequencer_pkg::*;

  state_t          state, state_next;
  logic [3:0]      a_q, b_q, dst_q;
  logic [OP_W-1:0] op_q;
  logic            wide_q;
  logic            wide_in;

`ifdef BUS_SEQUENCER_HILO_EN
  assign wide_in = wide;
`else
  logic unused_wide;
  assign unused_wide = wide;
  assign wide_in     = 1'b0;
`endif

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) state <= IDLE;
    else          state <= state_next;
  end

  // Operands are captured only on acceptance, so later input changes are ignored
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      a_q    <= '0;
      b_q    <= '0;
      dst_q  <= '0;
      op_q   <= '0;
      wide_q <= 1'b0;
    end else if (state == IDLE && start) begin
      a_q    <= src_a;
      b_q    <= src_b;
      dst_q  <= dst;
      op_q   <= op;
      wide_q <= wide_in;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start) state_next = T_A;
      T_A:   state_next = T_B;
      T_B:   state_next = T_WLO;
`ifdef BUS_SEQUENCER_HILO_EN
      T_WLO: state_next = wide_q ? T_WHI : DONE;
      T_WHI: state_next = DONE;
`else
      T_WLO: state_next = DONE;
`endif
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  logic [3:0]  src_idx;
  logic        src_en, dst_en;
  logic [15:0] src_onehot, dst_onehot;

  assign src_idx = (state == T_A) ? a_q : b_q;
  assign src_en  = (state == T_A) || (state == T_B);
  assign dst_en  = (state == T_WLO) && !wide_q;

  sel_decoder u_src_dec (.idx(src_idx), .en(src_en), .onehot(src_onehot));
  sel_decoder u_dst_dec (.idx(dst_q),   .en(dst_en), .onehot(dst_onehot));

  always_comb begin
    bus_sel       = '0;
    bus_sel[15:0] = src_onehot;
    reg_in        = dst_onehot;
    y_in          = 1'b0;
    z_in          = 1'b0;
    hi_in         = 1'b0;
    lo_in         = 1'b0;
    alu_op        = '0;
    busy          = (state != IDLE);
    done          = 1'b0;
    case (state)
      T_A:   y_in = 1'b1;
      T_B: begin
        alu_op = op_q;
        z_in   = 1'b1;
      end
      T_WLO: begin
        bus_sel[SEL_ZLO] = 1'b1;
`ifdef BUS_SEQUENCER_HILO_EN
        lo_in = wide_q;
`endif
      end
`ifdef BUS_SEQUENCER_HILO_EN
      T_WHI: begin
        bus_sel[SEL_ZHI] = 1'b1;
        hi_in            = 1'b1;
      end
`endif
      DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule
